// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, Rcon, word/block types
// and the key-expander state encoding.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE,
    EMIT
  } kx_state_t;

  localparam int NR = 14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [7] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] sub_byte(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  assign o_word = {
    sub_byte(i_word[31:24]),
    sub_byte(i_word[23:16]),
    sub_byte(i_word[15:8]),
    sub_byte(i_word[7:0])
  };

endmodule

// File: rtl/aes_key_expander.sv
// AES-256 iterative key expander: one 128-bit round key
// per clock, rounds 0..14, from a sliding 8-word window.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUND_KEYS = 15,
  parameter int KEY_BITS       = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] cipher_key,
  output logic                ready,
  output logic                busy,
  output logic                load,
  output logic [3:0]          round_number,
  output block_t              key,
  output logic                done
);

  if (NUM_ROUND_KEYS != NR + 1) begin : g_bad_nrk
    $error("aes_key_expander: NUM_ROUND_KEYS must be 15");
  end
  if (KEY_BITS != 256) begin : g_bad_kb
    $error("aes_key_expander: KEY_BITS must be 256");
  end

  localparam logic [3:0] LAST = 4'(NR);

  kx_state_t  r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  word_t      r_win [8];
  word_t      w_win_n [8];

  logic       r_ready, r_busy, r_load, r_done;
  logic [3:0] r_rn;
  block_t     r_key;

  logic       w_busy_n, w_load_n, w_done_n;
  logic [3:0] w_rn_n;
  block_t     w_key_n;

  word_t      w_sw_in, w_sw_out, w_t;
  word_t      w_n0, w_n1, w_n2, w_n3;
  logic [2:0] w_ridx;
  logic [7:0] w_rcon;

  // Odd rounds skip RotWord and Rcon (the Nk=8 extra SubWord step)
  assign w_sw_in = r_cnt[0] ? r_win[7]
                 : {r_win[7][23:0], r_win[7][31:24]};

  aes_sub_word u_sub (
    .i_word (w_sw_in),
    .o_word (w_sw_out)
  );

  assign w_ridx = r_cnt[3:1] - 3'd1;
  assign w_rcon = (r_cnt[0] || r_cnt < 4'd2) ? 8'h00
                : RCON[w_ridx];

  assign w_t  = w_sw_out ^ {w_rcon, 24'h0};
  assign w_n0 = r_win[0] ^ w_t;
  assign w_n1 = r_win[1] ^ w_n0;
  assign w_n2 = r_win[2] ^ w_n1;
  assign w_n3 = r_win[3] ^ w_n2;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_win_n   = r_win;
    w_load_n  = 1'b0;
    w_busy_n  = 1'b0;
    w_rn_n    = '0;
    w_key_n   = '0;
    w_done_n  = r_load && (r_rn == LAST);
    unique case (r_state)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            w_win_n[i] = cipher_key[KEY_BITS-1-32*i -: 32];
          end
          w_cnt_n   = '0;
          w_state_n = EMIT;
        end
      end
      EMIT: begin
        w_load_n = 1'b1;
        w_busy_n = 1'b1;
        w_rn_n   = r_cnt;
        unique case (1'b1)
          (r_cnt == 4'd0):
            w_key_n = {r_win[0], r_win[1],
                       r_win[2], r_win[3]};
          (r_cnt == 4'd1):
            w_key_n = {r_win[4], r_win[5],
                       r_win[6], r_win[7]};
          default: begin
            w_key_n = {w_n0, w_n1, w_n2, w_n3};
            for (int i = 0; i < 4; i++) begin
              w_win_n[i] = r_win[i+4];
            end
            w_win_n[4] = w_n0;
            w_win_n[5] = w_n1;
            w_win_n[6] = w_n2;
            w_win_n[7] = w_n3;
          end
        endcase
        if (r_cnt == LAST) w_state_n = IDLE;
        else               w_cnt_n   = r_cnt + 4'd1;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < 8; i++) r_win[i] <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_load  <= 1'b0;
      r_rn    <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_win   <= w_win_n;
      r_ready <= !w_busy_n;
      r_busy  <= w_busy_n;
      r_load  <= w_load_n;
      r_rn    <= w_rn_n;
      r_key   <= w_key_n;
      r_done  <= w_done_n;
    end
  end

  assign ready        = r_ready;
  assign busy         = r_busy;
  assign load         = r_load;
  assign round_number = r_rn;
  assign key          = r_key;
  assign done         = r_done;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors,
// handshake timing, back-to-back, mid-run reset, idle.
module tb_aes_key_expander;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] cipher_key;
  logic         ready, busy, load, done;
  logic [3:0]   round_number;
  logic [127:0] key;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cipher_key   (cipher_key),
    .ready        (ready),
    .busy         (busy),
    .load         (load),
    .round_number (round_number),
    .key          (key),
    .done         (done)
  );

  typedef logic [127:0] rk_arr_t [15];

  typedef struct {
    string        name;
    logic [255:0] ck;
    int           rnd;
    logic [127:0] exp_key;
    int           pa;
    int           pb;
  } vec_t;

  int      checks   = 0;
  int      failures = 0;
  rk_arr_t cap, exp_a, exp_b;
  vec_t    vt [6];

  localparam logic [255:0] K_C3 =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K_PI =
    256'h31415926535897932384626433832795_02884197169399375105820974944592;

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]),
            sub_byte(x[15:8]),  sub_byte(x[7:0])};
  endfunction

  // Textbook KeyExpansion over the full w[0..59] array
  task automatic model(input logic [255:0] k, output rk_arr_t rk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = sw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic chk_out(input string tag, input int e,
                         input logic e_load, input logic [3:0] e_rn,
                         input logic [127:0] e_key, input logic e_done);
    logic [135:0] act, want;
    act  = {load, busy, ready, done, round_number, key};
    want = {e_load, e_load, !e_load, e_done, e_rn, e_key};
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d load=%b busy=%b ready=%b done=%b rn=%0d key=%h want load=%b done=%b rn=%0d key=%h",
               tag, e, load, busy, ready, done, round_number, key,
               e_load, e_done, e_rn, e_key);
    end
  endtask

  task automatic run_expand(input logic [255:0] k, input int pa,
                            input int pb, input logic [255:0] junk,
                            input string tag);
    model(k, exp_a);
    @(negedge clk);
    start = 1'b1; cipher_key = k;
    @(negedge clk);
    start = (pa == 1) || (pb == 1); cipher_key = junk;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e <= 15) begin
        cap[e-1] = key;
        chk_out(tag, e, 1'b1, 4'(e-1), exp_a[e-1], 1'b0);
      end else begin
        chk_out(tag, e, 1'b0, 4'd0, '0, 1'b1);
      end
      start = (e + 1 == pa) || (e + 1 == pb);
    end
    start = 1'b0;
    @(negedge clk);
    chk_out({tag, "_post"}, 17, 1'b0, 4'd0, '0, 1'b0);
  endtask

  initial begin
    vt[0] = '{"c3_rk0",  K_C3, 0,
              128'h000102030405060708090a0b0c0d0e0f, 0, 0};
    vt[1] = '{"c3_rk1",  K_C3, 1,
              128'h101112131415161718191a1b1c1d1e1f, 0, 0};
    vt[2] = '{"c3_rk2",  K_C3, 2,
              128'ha573c29fa176c498a97fce93a572c09c, 0, 0};
    vt[3] = '{"c3_rk14_busy_start", K_C3, 14,
              128'h24fc79ccbf0979e9371ac23c6d68de36, 3, 10};
    vt[4] = '{"pi_rk0",  K_PI, 0,
              128'h31415926535897932384626433832795, 0, 0};
    vt[5] = '{"pi_rk1",  K_PI, 1,
              128'h02884197169399375105820974944592, 0, 0};

    rst = 1'b1; start = 1'b0; cipher_key = '0;
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 1'b0, 4'd0, '0, 1'b0);
    rst = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk_out("idle", c, 1'b0, 4'd0, '0, 1'b0);
    end

    for (int v = 0; v < 6; v++) begin
      run_expand(vt[v].ck, vt[v].pa, vt[v].pb,
                 vt[v].ck ^ K_PI ^ {8{32'h5a5aa5a5}}, vt[v].name);
      chk(vt[v].name, cap[vt[v].rnd], vt[v].exp_key);
    end

    // Back-to-back: start held high through done
    model(K_C3, exp_a);
    model(K_PI, exp_b);
    @(negedge clk);
    start = 1'b1; cipher_key = K_C3;
    @(negedge clk);
    cipher_key = K_PI;
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      if (e <= 15)
        chk_out("b2b_a", e, 1'b1, 4'(e-1), exp_a[e-1], 1'b0);
      else if (e == 16)
        chk_out("b2b_done_a", e, 1'b0, 4'd0, '0, 1'b1);
      else if (e <= 31)
        chk_out("b2b_b", e, 1'b1, 4'(e-17), exp_b[e-17], 1'b0);
      else
        chk_out("b2b_done_b", e, 1'b0, 4'd0, '0, 1'b1);
      if (e == 16) start = 1'b0;
    end
    @(negedge clk);
    chk_out("b2b_post", 33, 1'b0, 4'd0, '0, 1'b0);

    // Reset while round 7 is on the outputs
    @(negedge clk);
    start = 1'b1; cipher_key = K_C3;
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_out("pre_rst", e, 1'b1, 4'(e-1), exp_a[e-1], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_out("mid_rst", 0, 1'b0, 4'd0, '0, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk_out("post_rst", c, 1'b0, 4'd0, '0, 1'b0);
    end
    run_expand(K_PI, 0, 0, K_C3, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
